// File: rtl/prbs31_lock_checker_if.sv
// Bit-stream and status bundle for the PRBS31 lock checker.
//   master: drives data_in / data_in_valid / clr_counts, observes status
//   slave : the checker; consumes the stream, drives lock status and BER counts
interface prbs31_lock_checker_if;
  logic        data_in;
  logic        data_in_valid;
  logic        clr_counts;
  logic        locked;
  logic [31:0] total_bits;
  logic [31:0] total_bit_errors;
  logic        error_pulse;

  modport master (
    output data_in, data_in_valid, clr_counts,
    input  locked, total_bits, total_bit_errors, error_pulse
  );

  modport slave (
    input  data_in, data_in_valid, clr_counts,
    output locked, total_bits, total_bit_errors, error_pulse
  );
endinterface

// File: rtl/prbs31_lock_checker.sv
// Receive-end PRBS31 (x^31 + x^28 + 1) checker. Self-synchronises a local
// reference to the recovered bit stream, then counts checked bits and bit
// errors while locked. Drops lock and re-seeds when ERR_THRESH errors land
// inside one ERR_WINDOW-bit window.
//   clk, rstn          : rising-edge clock, async active-low reset
//   bus.data_in        : recovered bit, consumed when bus.data_in_valid=1
//   bus.clr_counts     : synchronous clear of the BER counters
//   bus.locked         : high while in LOCKED
//   bus.total_bits     : bits checked while locked (saturating)
//   bus.total_bit_errors : mismatches while locked (saturating)
//   bus.error_pulse    : one-cycle pulse per counted mismatch
module prbs31_lock_checker #(
  parameter int LOCK_BITS  = 64,
  parameter int ERR_WINDOW = 1024,
  parameter int ERR_THRESH = 16
) (
  input logic               clk,
  input logic               rstn,
  prbs31_lock_checker_if.slave bus
);
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  localparam logic [7:0]  LOCK_L = 8'(LOCK_BITS);
  localparam logic [15:0] WIN_L  = 16'(ERR_WINDOW);
  localparam logic [15:0] THR_L  = 16'(ERR_THRESH);

  state_t      state_q, state_d;
  logic [30:0] r_q, r_d;          // r[0] newest, r[30] oldest
  logic [4:0]  seed_q, seed_d;
  logic [7:0]  match_q, match_d;
  logic [15:0] wbits_q, wbits_d;
  logic [15:0] werrs_q, werrs_d;
  logic [31:0] tbits_q, tbits_d;
  logic [31:0] terrs_q, terrs_d;
  logic        pulse_q, pulse_d;
  logic        locked_q;

  logic        pred, mis;
  logic [7:0]  match_inc;
  logic [15:0] wbits_inc, werrs_inc;

  assign pred      = r_q[30] ^ r_q[27];
  assign mis       = bus.data_in ^ pred;
  assign match_inc = match_q + 8'd1;
  assign wbits_inc = wbits_q + 16'd1;
  assign werrs_inc = werrs_q + {15'd0, mis};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    seed_d  = seed_q;
    match_d = match_q;
    wbits_d = wbits_q;
    werrs_d = werrs_q;
    tbits_d = tbits_q;
    terrs_d = terrs_q;
    pulse_d = 1'b0;
    if (bus.data_in_valid) begin
      unique case (state_q)
        SEED: begin
          r_d    = {r_q[29:0], bus.data_in};
          seed_d = seed_q + 5'd1;
          if (seed_q == 5'd30) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          // Received bit goes in: a bad bit only poisons the next 31 predictions.
          r_d = {r_q[29:0], bus.data_in};
          if (r_q == '0) begin
            match_d = '0;               // dead register: never lock on zeros
          end else if (!mis) begin
            match_d = match_inc;
            if (match_inc == LOCK_L) begin
              state_d = LOCKED;
              wbits_d = '0;
              werrs_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so one channel error counts once.
          r_d = {r_q[29:0], pred};
          if (tbits_q != '1) tbits_d = tbits_q + 32'd1;
          if (mis) begin
            pulse_d = 1'b1;
            if (terrs_q != '1) terrs_d = terrs_q + 32'd1;
          end
          wbits_d = wbits_inc;
          werrs_d = werrs_inc;
          if (werrs_inc >= THR_L) begin
            state_d = SEED;
            seed_d  = '0;
          end else if (wbits_inc == WIN_L) begin
            wbits_d = '0;
            werrs_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (bus.clr_counts) begin
      tbits_d = '0;
      terrs_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= SEED;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q      <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      wbits_q  <= '0;
      werrs_q  <= '0;
      tbits_q  <= '0;
      terrs_q  <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      seed_q   <= seed_d;
      match_q  <= match_d;
      wbits_q  <= wbits_d;
      werrs_q  <= werrs_d;
      tbits_q  <= tbits_d;
      terrs_q  <= terrs_d;
      pulse_q  <= pulse_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign bus.locked           = locked_q;
  assign bus.total_bits       = tbits_q;
  assign bus.total_bit_errors = terrs_q;
  assign bus.error_pulse      = pulse_q;
endmodule

// File: doc/prbs31_lock_checker.md
# prbs31_lock_checker

Receive-end PRBS31 checker that closes the loop on the PRBS31 generator → Gray PAM-4 encode → Gray decode chain. It takes the recovered serial bit stream from the Gray decoder, self-synchronises a local PRBS31 reference to it, then counts checked bits and bit errors for BER reporting. It declares loss of lock and re-synchronises automatically when the error density exceeds a threshold.

## Interface
- LOCK_BITS, 64: consecutive correctly-predicted bits required in VERIFY before declaring lock (1..255).
- ERR_WINDOW, 1024: window length in checked bits for loss-of-lock evaluation (2..65535).
- ERR_THRESH, 16: errors within one window that force re-sync (1..ERR_WINDOW).
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  reset, asynchronous and active-low.
- data_in  in  1  recovered bit from the Gray decoder.
- data_in_valid  in  1  qualifies data_in; one bit consumed per cycle while high.
- clr_counts  in  1  synchronous clear of total_bits/total_bit_errors; lock state untouched.
- locked  out  1  high while in LOCKED.
- total_bits  out  32  bits checked while locked; saturating.
- total_bit_errors  out  32  mismatches while locked; saturating.
- error_pulse  out  1  one-cycle pulse per counted mismatch.

## Operation
- Sequence definition: b[n] = b[n-31] XOR b[n-28] (x^31 + x^28 + 1).
- 31-bit history r: r[0] is the newest bit, r[30] the oldest; prediction p = r[30] ^ r[27].
- Only cycles with data_in_valid=1 do anything. Invalid cycles hold all state, with no counts and no pulses.
- SEED:
  - Shift data_in into r and increment the seed counter.
  - After the 31st valid bit, go to VERIFY and clear the match counter.
- VERIFY:
  - Compare data_in against p, then shift data_in (the received bit) into r. Errors do not persist because the register self-synchronises.
  - Match with r ≠ 0: increment the match counter. On reaching LOCK_BITS, go to LOCKED and clear the window counters.
  - Mismatch: clear the match counter and stay in VERIFY.
  - r all-zero: the match counter holds at 0. An all-zero stream never locks.
- LOCKED:
  - Shift p (the predicted bit, not data_in) into r, so a single channel error counts exactly once.
  - total_bits increments on every valid bit.
  - On mismatch, total_bit_errors increments and error_pulse is asserted.
  - A window bit counter and a window error counter advance on each valid bit.
  - If the window error count including the current bit reaches ERR_THRESH: go to SEED, clear the seed counter, deassert locked. The current bit is still counted.
  - When the window bit counter reaches ERR_WINDOW without hitting the threshold, both window counters clear.
- Counters saturate at 0xFFFFFFFF and never wrap.
- clr_counts has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values: locked=0, total_bits=0, total_bit_errors=0, error_pulse=0, state=SEED, r=0, all internal counters=0.
- All outputs are registered. The effect of a valid bit sampled at edge k is visible after edge k.
- Time to lock with a clean stream and continuous valid: 31 + LOCK_BITS valid bits. locked rises on the edge that samples bit 31+LOCK_BITS.
- Counting starts with the first valid bit after locked rises.
- error_pulse is high for exactly the cycle after the edge that sampled the mismatching bit.
- Loss of lock: locked falls on the same edge that counts the ERR_THRESH-th window error.
- Asynchronous reset asserted mid-operation immediately forces all reset values, including clearing counts.

## Test plan
- Clean PRBS31 stream from the generator, continuous valid, LOCK_BITS=64 → locked rises after bit 95. After 10000 further bits: total_bits=10000, total_bit_errors=0, no error_pulse.
- Locked, single data_in inversion at one bit, 1000 bits total → total_bit_errors=1, exactly one error_pulse, locked stays 1.
- Locked, ERR_THRESH=16, inject 16 consecutive inverted bits → locked falls on the 16th error and total_bit_errors=16. A clean stream then relocks after a further 31+64 bits.
- All-zero input with valid high for 5000 cycles → locked stays 0 and both counts stay 0.
- Clean stream with valid toggled pseudo-randomly (about 50% duty) → lock after 95 valid bits. total_bits equals the number of valid bits after lock, with 0 errors.
- Assert clr_counts while locked and simultaneously counting an error → counts read 0 and locked stays 1. Pulse rstn low mid-stream → all outputs return to 0, then relock after 95 bits.
